uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver. It accepts received characters plus their parity/frame error flags on an AXI4-Stream slave port and stores them in a DEPTH-entry first-word-fall-through FIFO. It presents them to the CPU/interconnect side on an AXI4-Stream master port. Characters that arrive while the FIFO is full are dropped, and each drop sets a sticky overflow flag.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_fifo_ram.sv | 23 ++
 rtl/uart_rx_fifo.sv | 101 ++++++++++
 tb/tb_uart_rx_fifo.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path types: tuser bit positions and the stored FIFO entry layout.
package uart_pkg;

  localparam int UART_TUSER_W   = 2;
  localparam int UART_TUSER_PAR = 0;
  localparam int UART_TUSER_FRM = 1;
  localparam int UART_DWIDTH    = 8;

  typedef struct packed {
    logic                   frm;
    logic                   par;
    logic                   last;
    logic [UART_DWIDTH-1:0] data;
  } uart_rx_entry_t;

  // Stored entry width: data plus frame, parity and last flags.
  function automatic int uart_entry_w(input int dwidth);
    return dwidth + 3;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// One-write/one-read register array with asynchronous read; no reset, contents are don't-care.
module uart_fifo_ram #(
  parameter int EW    = 11,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO between the UART receiver and the CPU side.
// Beats arriving while full are dropped and latch a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                     uart_clk,
  input  logic                     uart_rst,
  input  logic [DWIDTH-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  input  logic                     s_parity_err,
  input  logic                     s_frame_err,
  output logic [DWIDTH-1:0]        m_axis_tdata,
  output logic [UART_TUSER_W-1:0]  m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic                     rx_flush,
  input  logic                     rx_ovf_clr,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     rx_almost_full,
  output logic                     rx_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = uart_entry_w(DWIDTH);
  localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LVL);

  typedef struct packed {
    logic              frm;
    logic              par;
    logic              last;
    logic [DWIDTH-1:0] data;
  } entry_t;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop, drop;
  entry_t        wr_entry, rd_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Ready depends only on local state, never on m_axis_tready.
  assign s_axis_tready = !uart_rst && !full && !rx_flush;
  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = !empty && m_axis_tready && !rx_flush;
  assign drop = s_axis_tvalid && !s_axis_tready && !rx_flush;

  always_ff @(posedge uart_clk or posedge uart_rst) begin
    if (uart_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (rx_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge uart_clk or posedge uart_rst) begin
    if (uart_rst)        rx_overflow <= 1'b0;
    else if (drop)       rx_overflow <= 1'b1;
    else if (rx_ovf_clr) rx_overflow <= 1'b0;
  end

  assign wr_entry = '{frm: s_frame_err, par: s_parity_err, last: s_axis_tlast, data: s_axis_tdata};

  uart_fifo_ram #(
    .EW    (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (uart_clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : rd_entry.data;
  assign m_axis_tlast  = !empty && rd_entry.last;
  always_comb begin
    m_axis_tuser                 = '0;
    m_axis_tuser[UART_TUSER_PAR] = !empty && rd_entry.par;
    m_axis_tuser[UART_TUSER_FRM] = !empty && rd_entry.frm;
  end

  assign rx_count       = wr_ptr - rd_ptr;
  assign rx_almost_full = (rx_count >= AFULL_THR);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = DEPTH - 2;

  logic          uart_clk, uart_rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          s_parity_err, s_frame_err;
  logic [DW-1:0] m_axis_tdata;
  logic [1:0]    m_axis_tuser;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic          rx_flush, rx_ovf_clr;
  logic [4:0]    rx_count;
  logic          rx_almost_full, rx_overflow;

  uart_rx_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .uart_clk       (uart_clk),
    .uart_rst       (uart_rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .s_parity_err   (s_parity_err),
    .s_frame_err    (s_frame_err),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .rx_flush       (rx_flush),
    .rx_ovf_clr     (rx_ovf_clr),
    .rx_count       (rx_count),
    .rx_almost_full (rx_almost_full),
    .rx_overflow    (rx_overflow)
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  // Model entry layout: {frame, parity, last, data}.
  logic [10:0] mq[$];
  bit          m_ovf;
  bit          m_rst;
  int          n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [10:0] h;
    h = (mq.size() != 0) ? mq[0] : 11'd0;
    chk("tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
    chk("tdata",  32'(m_axis_tdata),  32'(h[7:0]));
    chk("tlast",  32'(m_axis_tlast),  32'(h[8]));
    chk("tuser",  32'(m_axis_tuser),  32'({h[10], h[9]}));
    chk("count",  32'(rx_count),      32'(mq.size()));
    chk("afull",  32'(rx_almost_full), 32'(mq.size() >= AFULL));
    chk("ovf",    32'(rx_overflow),   32'(m_ovf));
    chk("tready", 32'(s_axis_tready), 32'(!m_rst && mq.size() < DEPTH && !rx_flush));
  endtask

  // Decide the edge's effect from the queue rules, then compare after the edge.
  task automatic cycle();
    bit rdy, pu, po, dr;
    rdy = (mq.size() < DEPTH) && !rx_flush;
    pu  = s_axis_tvalid && rdy;
    po  = (mq.size() != 0) && m_axis_tready && !rx_flush;
    dr  = s_axis_tvalid && !rdy && !rx_flush;
    @(posedge uart_clk);
    if (rx_flush) mq.delete();
    else begin
      if (po) mq.delete(0);
      if (pu) mq.push_back({s_frame_err, s_parity_err, s_axis_tlast, s_axis_tdata});
    end
    if (dr) m_ovf = 1'b1;
    else if (rx_ovf_clr) m_ovf = 1'b0;
    @(negedge uart_clk);
    check_outputs();
  endtask

  task automatic beat(input logic [7:0] d, input logic p, input logic f, input logic l);
    s_axis_tdata  = d;
    s_parity_err  = p;
    s_frame_err   = f;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    cycle();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    uart_rst = 1'b1; m_rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_parity_err = 1'b0; s_frame_err = 1'b0; m_axis_tready = 1'b0;
    rx_flush = 1'b0; rx_ovf_clr = 1'b0;
    m_ovf = 1'b0;
    #2 check_outputs();
    @(negedge uart_clk);
    uart_rst = 1'b0;
    #1 m_rst = 1'b0;
    check_outputs();

    // Ordering with error flags, held then released.
    beat(8'h41, 1'b0, 1'b0, 1'b0);
    beat(8'h42, 1'b1, 1'b0, 1'b0);
    beat(8'h43, 1'b0, 1'b1, 1'b1);
    idle(2);
    m_axis_tready = 1'b1;
    idle(4);
    m_axis_tready = 1'b0;

    // Fill, overflow, drain.
    for (int i = 0; i < DEPTH; i++) beat(8'(i), 1'b0, 1'b0, 1'b0);
    beat(8'hAA, 1'b0, 1'b0, 1'b0);
    idle(1);
    m_axis_tready = 1'b1;
    idle(DEPTH + 2);
    m_axis_tready = 1'b0;

    // Steady occupancy with concurrent push/pop, pointers wrap.
    for (int i = 0; i < 3; i++) beat(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 20; i++) beat(8'h20 + 8'(i), i[0], i[1], i[2]);
    m_axis_tready = 1'b0;
    while (mq.size() < DEPTH) beat(8'($urandom), 1'b0, 1'b0, 1'b0);
    m_axis_tready = 1'b1;
    beat(8'hBB, 1'b0, 1'b0, 1'b0);
    m_axis_tready = 1'b0;
    idle(1);

    // Flush with a concurrent push.
    rx_flush = 1'b1; cycle(); rx_flush = 1'b0;
    for (int i = 0; i < 7; i++) beat(8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    rx_flush = 1'b1;
    beat(8'h55, 1'b0, 1'b0, 1'b0);
    rx_flush = 1'b0;
    idle(1);

    // Overflow clear alone, then clear coincident with a drop.
    rx_ovf_clr = 1'b1; cycle(); rx_ovf_clr = 1'b0;
    while (mq.size() < DEPTH) beat(8'($urandom), 1'b0, 1'b0, 1'b0);
    beat(8'hCC, 1'b0, 1'b0, 1'b0);
    rx_ovf_clr = 1'b1;
    beat(8'hCD, 1'b0, 1'b0, 1'b0);
    rx_ovf_clr = 1'b0;
    idle(1);

    // Randomized traffic with shifting producer/consumer bias.
    for (int seg = 0; seg < 16; seg++) begin
      int vb, rb;
      vb = $urandom_range(1, 9);
      rb = $urandom_range(1, 9);
      for (int i = 0; i < 200; i++) begin
        s_axis_tvalid = ($urandom_range(0, 9) < vb);
        s_axis_tdata  = 8'($urandom);
        s_axis_tlast  = 1'($urandom);
        s_parity_err  = 1'($urandom);
        s_frame_err   = 1'($urandom);
        m_axis_tready = ($urandom_range(0, 9) < rb);
        rx_flush      = ($urandom_range(0, 99) == 0);
        rx_ovf_clr    = ($urandom_range(0, 31) == 0);
        cycle();
      end
    end
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b0; rx_flush = 1'b0; rx_ovf_clr = 1'b0;
    idle(1);

    // Asynchronous reset with entries stored and overflow set.
    rx_flush = 1'b1; cycle(); rx_flush = 1'b0;
    for (int i = 0; i < 5; i++) beat(8'h70 + 8'(i), 1'b0, 1'b0, 1'b0);
    while (mq.size() < DEPTH) beat(8'($urandom), 1'b0, 1'b0, 1'b0);
    beat(8'hEE, 1'b0, 1'b0, 1'b0);
    m_axis_tready = 1'b1;
    for (int i = 0; i < DEPTH - 5; i++) cycle();
    m_axis_tready = 1'b0;
    idle(1);
    #1 uart_rst = 1'b1;
    #1 mq.delete(); m_ovf = 1'b0; m_rst = 1'b1;
    check_outputs();
    @(negedge uart_clk);
    uart_rst = 1'b0;
    #1 m_rst = 1'b0;
    check_outputs();
    beat(8'h99, 1'b1, 1'b0, 1'b1);
    m_axis_tready = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
